mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Arbitrates a single shared RAM port between two requesters: the memory stage (data port, D) and instruction fetch (I).
- Sequences each access as a multi-cycle handshake. Holds RAM-side signals stable until the RAM acknowledges, then returns read data and a one-cycle done pulse to the granted requester.
- Sits between the pipeline stages and the RAM model. Replaces direct stage-to-RAM wiring.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, cycles in ACCESS without ram_ack before the access is aborted.
- TIMEOUT_W, 8, width of the timeout counter; must satisfy TIMEOUT < 2^TIMEOUT_W.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous reset, active-high.
- d_req  in  1  data access request; held until d_done.
- d_we  in  1  1 = store, 0 = load; sampled with d_req.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load result (registered).
- d_done  out  1  one-cycle completion pulse.
- i_req  in  1  fetch request; held until i_done.
- i_addr  in  ADDR_W  fetch address.
- i_rdata  out  DATA_W  fetched word (registered).
- i_done  out  1  one-cycle completion pulse.
- ram_en  out  1  RAM access valid.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data; valid when ram_ack = 1.
- ram_ack  in  1  RAM completion, sampled on posedge.
- err  out  1  one-cycle pulse, coincident with done, when an access times out.

Behaviour:
- Reset (async): state = IDLE. All outputs 0, including d_rdata and i_rdata. Timeout counter 0, last-grant flag = I. Reset mid-access drops ram_en immediately; the access is abandoned with no done pulse.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - On a posedge with d_req or i_req high, select the grantee: D has priority unless round-robin is enabled.
  - Register ram_addr, ram_wdata and ram_we from the grantee. Fetch always drives ram_we = 0 and ram_wdata = 0.
  - Set ram_en = 1, clear the timeout counter, go to ACCESS.
  - ram_ack received in IDLE is ignored.
- ACCESS:
  - ram_en, ram_we, ram_addr and ram_wdata are held constant.
  - On a posedge with ram_ack = 1:
    - For a load or fetch, capture ram_rdata into the grantee's rdata register.
    - Pulse the grantee's done for exactly one cycle.
    - Set ram_en = 0 and ram_we = 0; go to DONE.
  - Without ram_ack, the counter increments. On the posedge where the counter equals TIMEOUT:
    - Abort: pulse done and err together; set the grantee's rdata = 0.
    - Set ram_en = 0; go to DONE.
- DONE: one bubble cycle so the requester can drop req; then go to IDLE. No new grant is issued in DONE.
- Latency:
  - req sampled at edge N gives ram_en = 1 after edge N.
  - ram_ack sampled at edge M gives done = 1 after edge M.
  - Next grant earliest at edge M+2.
  - Minimum request-to-done is 2 cycles (ack at edge N+1).
- Stores leave d_rdata unchanged.
- A req deasserted during ACCESS does not cancel the access: it completes and done still pulses.
- Non-granted requester's rdata and done are untouched throughout.
- At most one of d_done or i_done is high in any cycle.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: when d_req and i_req are both high in IDLE, the requester not granted last wins. The last-grant flag updates at every grant. A single requester is always granted.
- Undefined: fixed priority, D always wins ties. I can starve under back-to-back data traffic. The last-grant flag is not implemented.

Test Plan:
- Load: d_req=1, d_we=0, d_addr=0x10; RAM acks 3 cycles after ram_en with 0xDEADBEEF -> ram_en high 3 cycles with ram_addr=0x10; d_rdata=0xDEADBEEF; d_done pulses 1 cycle; err=0.
- Store: d_req=1, d_we=1, d_addr=0x20, d_wdata=0x12345678; ack after 1 cycle -> ram_we=1 and ram_wdata=0x12345678 during ACCESS; d_done pulses; d_rdata unchanged.
- Simultaneous: d_req and i_req rise together, both held, RAM acks after 1 cycle.
  - Fixed priority: D served first, then I with ram_addr=i_addr.
  - With MEM_ARB_ROUND_ROBIN_EN, after reset: D first (last grant = I), then I; a repeated tie alternates D, I, D, I.
- Timeout: TIMEOUT=4, ram_ack tied 0 -> ram_en high exactly 5 cycles; i_done and err pulse together; i_rdata=0; FSM returns to IDLE.
- Reset mid-access: assert rst during ACCESS (between edges) -> ram_en drops 0 immediately, no done pulse; after release, a new i_req is granted normally.
- Request drop: d_req deasserted 1 cycle into ACCESS -> access completes; d_done still pulses on ack.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of the requester (D/I) and RAM-side signals of the
// shared memory-port arbiter. The slave modport is the arbiter's view. The
// master modport is the view of the pipeline stages and the RAM model.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_done;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_done;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_ack;
  logic              err;

  modport slave (
    input  d_req, d_we, d_addr, d_wdata, i_req, i_addr, ram_rdata, ram_ack,
    output d_rdata, d_done, i_rdata, i_done, ram_en, ram_we, ram_addr,
           ram_wdata, err
  );

  modport master (
    output d_req, d_we, d_addr, d_wdata, i_req, i_addr, ram_rdata, ram_ack,
    input  d_rdata, d_done, i_rdata, i_done, ram_en, ram_we, ram_addr,
           ram_wdata, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between the data port (D) and instruction
// fetch (I). Each access follows the sequence IDLE -> ACCESS -> DONE.
// RAM-side signals are held until ram_ack arrives. An access with no ack
// for TIMEOUT cycles is aborted with err.
// Optional macro MEM_ARB_ROUND_ROBIN_EN: when both sides request together,
// the grant alternates. Without this macro, D always wins a tie.
module mem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 255,
  parameter int TIMEOUT_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  localparam logic [TIMEOUT_W-1:0] TIMEOUT_CNT = TIMEOUT_W'(TIMEOUT);

  state_t                state_q, state_d;
  logic                  gnt_d_q, gnt_d_d;     // 1 = current grantee is D
  logic [TIMEOUT_W-1:0]  cnt_q, cnt_d;
  logic                  ram_en_q, ram_en_d;
  logic                  ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]     ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]     ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0]     d_rdata_q, d_rdata_d;
  logic [DATA_W-1:0]     i_rdata_q, i_rdata_d;
  logic                  d_done_q, d_done_d;
  logic                  i_done_q, i_done_d;
  logic                  err_q, err_d;
  logic                  pick_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic                  last_i_q, last_i_d;   // 1 = last grant went to I
`endif

  // Grant selection for a request seen in IDLE
  always_comb begin
    pick_d = bus.d_req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (bus.d_req && bus.i_req) pick_d = last_i_q;
`endif
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    gnt_d_d     = gnt_d_q;
    cnt_d       = cnt_q;
    ram_en_d    = ram_en_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    d_rdata_d   = d_rdata_q;
    i_rdata_d   = i_rdata_q;
    d_done_d    = 1'b0;
    i_done_d    = 1'b0;
    err_d       = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_i_d    = last_i_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.d_req || bus.i_req) begin
          gnt_d_d     = pick_d;
          ram_en_d    = 1'b1;
          ram_we_d    = pick_d ? bus.d_we : 1'b0;
          ram_addr_d  = pick_d ? bus.d_addr : bus.i_addr;
          ram_wdata_d = pick_d ? bus.d_wdata : '0;
          cnt_d       = '0;
          state_d     = S_ACCESS;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_i_d    = ~pick_d;
`endif
        end
      end
      S_ACCESS: begin
        if (bus.ram_ack) begin
          if (gnt_d_q) begin
            d_done_d = 1'b1;
            if (!ram_we_q) d_rdata_d = bus.ram_rdata;
          end else begin
            i_done_d  = 1'b1;
            i_rdata_d = bus.ram_rdata;
          end
          ram_en_d = 1'b0;
          ram_we_d = 1'b0;
          state_d  = S_DONE;
        end else if (cnt_q == TIMEOUT_CNT) begin
          if (gnt_d_q) begin
            d_done_d  = 1'b1;
            d_rdata_d = '0;
          end else begin
            i_done_d  = 1'b1;
            i_rdata_d = '0;
          end
          err_d    = 1'b1;
          ram_en_d = 1'b0;
          ram_we_d = 1'b0;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + TIMEOUT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; async reset abandons any access in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gnt_d_q     <= 1'b0;
      cnt_q       <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      d_rdata_q   <= '0;
      i_rdata_q   <= '0;
      d_done_q    <= 1'b0;
      i_done_q    <= 1'b0;
      err_q       <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_i_q    <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      gnt_d_q     <= gnt_d_d;
      cnt_q       <= cnt_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      d_rdata_q   <= d_rdata_d;
      i_rdata_q   <= i_rdata_d;
      d_done_q    <= d_done_d;
      i_done_q    <= i_done_d;
      err_q       <= err_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_i_q    <= last_i_d;
`endif
    end
  end

  assign bus.ram_en    = ram_en_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_done    = d_done_q;
  assign bus.i_done    = i_done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed tests of mem_arbiter with hand-computed
// expectations. TIMEOUT is set to 4 for this bench.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4), .TIMEOUT_W(8)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.i_req = 0; bus.i_addr = '0; bus.ram_rdata = '0; bus.ram_ack = 0;
  endtask

  task automatic test_reset;
    idle_inputs();
    #12;
    checks++; if (bus.ram_en !== 1'b0) begin failures++; $display("FAIL rst_ram_en got=%0h exp=0", bus.ram_en); end
    checks++; if (bus.ram_we !== 1'b0) begin failures++; $display("FAIL rst_ram_we got=%0h exp=0", bus.ram_we); end
    checks++; if (bus.ram_addr !== 32'h0) begin failures++; $display("FAIL rst_ram_addr got=%0h exp=0", bus.ram_addr); end
    checks++; if ({bus.d_done, bus.i_done, bus.err} !== 3'b000) begin failures++; $display("FAIL rst_pulses got=%0b exp=000", {bus.d_done, bus.i_done, bus.err}); end
    checks++; if (bus.d_rdata !== 32'h0) begin failures++; $display("FAIL rst_d_rdata got=%0h exp=0", bus.d_rdata); end
    checks++; if (bus.i_rdata !== 32'h0) begin failures++; $display("FAIL rst_i_rdata got=%0h exp=0", bus.i_rdata); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_load;
    int en_cycles = 0;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h10;
    tick();
    checks++; if (bus.ram_addr !== 32'h10) begin failures++; $display("FAIL load_addr got=%0h exp=10", bus.ram_addr); end
    checks++; if (bus.ram_we !== 1'b0) begin failures++; $display("FAIL load_we got=%0h exp=0", bus.ram_we); end
    for (int k = 0; k < 3; k++) begin
      if (bus.ram_en === 1'b1) en_cycles++;
      if (k == 2) begin bus.ram_ack = 1; bus.ram_rdata = 32'hDEADBEEF; end
      tick();
    end
    checks++; if (en_cycles != 3) begin failures++; $display("FAIL load_en_cycles got=%0d exp=3", en_cycles); end
    checks++; if (bus.ram_en !== 1'b0) begin failures++; $display("FAIL load_en_drop got=%0h exp=0", bus.ram_en); end
    checks++; if (bus.d_done !== 1'b1 || bus.i_done !== 1'b0) begin failures++; $display("FAIL load_done got=%0b%0b exp=10", bus.d_done, bus.i_done); end
    checks++; if (bus.d_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL load_rdata got=%0h exp=deadbeef", bus.d_rdata); end
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL load_err got=%0h exp=0", bus.err); end
    bus.ram_ack = 0; bus.d_req = 0;
    tick();
    checks++; if (bus.d_done !== 1'b0) begin failures++; $display("FAIL load_done_width got=%0h exp=0", bus.d_done); end
  endtask

  task automatic test_store;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h20; bus.d_wdata = 32'h12345678;
    tick();
    checks++; if (bus.ram_en !== 1'b1 || bus.ram_we !== 1'b1) begin failures++; $display("FAIL store_en_we got=%0b%0b exp=11", bus.ram_en, bus.ram_we); end
    checks++; if (bus.ram_wdata !== 32'h12345678) begin failures++; $display("FAIL store_wdata got=%0h exp=12345678", bus.ram_wdata); end
    checks++; if (bus.ram_addr !== 32'h20) begin failures++; $display("FAIL store_addr got=%0h exp=20", bus.ram_addr); end
    bus.ram_ack = 1; bus.ram_rdata = 32'hFFFF0000;
    tick();
    checks++; if (bus.d_done !== 1'b1) begin failures++; $display("FAIL store_done got=%0h exp=1", bus.d_done); end
    checks++; if (bus.d_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL store_rdata_kept got=%0h exp=deadbeef", bus.d_rdata); end
    checks++; if (bus.ram_we !== 1'b0) begin failures++; $display("FAIL store_we_drop got=%0h exp=0", bus.ram_we); end
    bus.ram_ack = 0; bus.d_req = 0; bus.d_we = 0;
    tick();
  endtask

  task automatic test_simultaneous;
    logic [2:0] exp_seq;
    logic       is_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_seq = 3'b101;  // bit k = grant k goes to D
`else
    exp_seq = 3'b111;
`endif
    rst = 1; #1; rst = 0;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h30;
    bus.i_req = 1; bus.i_addr = 32'h40;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) bus.d_req = 0;
      is_d = (k < 3) ? exp_seq[k] : 1'b0;
      tick();
      checks++; if (bus.ram_addr !== (is_d ? 32'h30 : 32'h40)) begin failures++; $display("FAIL sim_addr%0d got=%0h exp=%0h", k, bus.ram_addr, is_d ? 32'h30 : 32'h40); end
      bus.ram_ack = 1; bus.ram_rdata = 32'h100 + k;
      tick();
      bus.ram_ack = 0;
      checks++; if ({bus.d_done, bus.i_done} !== {is_d, ~is_d}) begin failures++; $display("FAIL sim_done%0d got=%0b%0b exp=%0b%0b", k, bus.d_done, bus.i_done, is_d, ~is_d); end
      checks++; if ((is_d ? bus.d_rdata : bus.i_rdata) !== 32'h100 + k) begin failures++; $display("FAIL sim_rdata%0d got=%0h exp=%0h", k, is_d ? bus.d_rdata : bus.i_rdata, 32'h100 + k); end
      tick();
      checks++; if (bus.ram_en !== 1'b0) begin failures++; $display("FAIL sim_bubble%0d got=%0h exp=0", k, bus.ram_en); end
    end
    bus.i_req = 0;
    tick();
  endtask

  task automatic test_timeout;
    int en_cycles = 0;
    int n = 0;
    bus.i_req = 1; bus.i_addr = 32'h50;
    tick();
    while (bus.ram_en === 1'b1 && n < 20) begin
      en_cycles++; n++;
      checks++; if (bus.err !== 1'b0 || bus.i_done !== 1'b0) begin failures++; $display("FAIL to_early got=%0b%0b exp=00", bus.err, bus.i_done); end
      tick();
    end
    checks++; if (en_cycles != 5) begin failures++; $display("FAIL to_en_cycles got=%0d exp=5", en_cycles); end
    checks++; if (bus.i_done !== 1'b1 || bus.err !== 1'b1) begin failures++; $display("FAIL to_done_err got=%0b%0b exp=11", bus.i_done, bus.err); end
    checks++; if (bus.i_rdata !== 32'h0) begin failures++; $display("FAIL to_rdata got=%0h exp=0", bus.i_rdata); end
    checks++; if (bus.d_done !== 1'b0) begin failures++; $display("FAIL to_d_done got=%0h exp=0", bus.d_done); end
    bus.i_req = 0;
    tick();
    checks++; if (bus.err !== 1'b0 || bus.i_done !== 1'b0) begin failures++; $display("FAIL to_pulse_width got=%0b%0b exp=00", bus.err, bus.i_done); end
    tick();
    checks++; if (bus.ram_en !== 1'b0) begin failures++; $display("FAIL to_idle got=%0h exp=0", bus.ram_en); end
  endtask

  task automatic test_reset_mid;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h60;
    tick();
    checks++; if (bus.ram_en !== 1'b1) begin failures++; $display("FAIL rm_grant got=%0h exp=1", bus.ram_en); end
    #2 rst = 1;
    #1;
    checks++; if (bus.ram_en !== 1'b0) begin failures++; $display("FAIL rm_en_drop got=%0h exp=0", bus.ram_en); end
    bus.d_req = 0;
    tick();
    rst = 0;
    tick();
    checks++; if (bus.d_done !== 1'b0 || bus.ram_en !== 1'b0) begin failures++; $display("FAIL rm_no_done got=%0b%0b exp=00", bus.d_done, bus.ram_en); end
    bus.i_req = 1; bus.i_addr = 32'h70;
    tick();
    checks++; if (bus.ram_en !== 1'b1 || bus.ram_addr !== 32'h70 || bus.ram_we !== 1'b0) begin failures++; $display("FAIL rm_regrant got=%0b/%0h exp=1/70", bus.ram_en, bus.ram_addr); end
    bus.ram_ack = 1; bus.ram_rdata = 32'h77;
    tick();
    checks++; if (bus.i_done !== 1'b1 || bus.i_rdata !== 32'h77) begin failures++; $display("FAIL rm_fetch got=%0b/%0h exp=1/77", bus.i_done, bus.i_rdata); end
    bus.ram_ack = 0; bus.i_req = 0;
    tick();
  endtask

  task automatic test_req_drop;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h80;
    tick();
    bus.d_req = 0;
    tick();
    checks++; if (bus.ram_en !== 1'b1 || bus.ram_addr !== 32'h80 || bus.d_done !== 1'b0) begin failures++; $display("FAIL drop_hold got=%0b/%0h/%0b exp=1/80/0", bus.ram_en, bus.ram_addr, bus.d_done); end
    bus.ram_ack = 1; bus.ram_rdata = 32'hCAFE;
    tick();
    checks++; if (bus.d_done !== 1'b1 || bus.d_rdata !== 32'hCAFE) begin failures++; $display("FAIL drop_done got=%0b/%0h exp=1/cafe", bus.d_done, bus.d_rdata); end
    bus.ram_ack = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_simultaneous();
    test_timeout();
    test_reset_mid();
    test_req_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
